// File: rtl/bk_pkg.sv
// Shared definitions for Brent-Kung adder users.
// Holds the stream state encoding and the default limb width.
package bk_pkg;

   localparam int BK_ADDER_SIZE = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } bk_stream_state_t;

endpackage

// File: rtl/brent_kung_adder_nbit.sv
// Combinational Brent-Kung prefix adder of arbitrary width.
// Up-sweep builds power-of-two groups, down-sweep fills the gaps.
module brent_kung_adder_nbit
   import bk_pkg::*;
#(
   parameter int ADDER_SIZE = BK_ADDER_SIZE
) (
   input  logic [ADDER_SIZE-1:0] a,
   input  logic [ADDER_SIZE-1:0] b,
   input  logic                  cin,
   output logic [ADDER_SIZE-1:0] sum,
   output logic                  cout
);

   localparam int N    = ADDER_SIZE;
   localparam int DTOP = (N > 1) ? (1 << ($clog2(N) - 1)) : 1;

   logic [N-1:0] p;
   logic [N-1:0] gg;
   logic [N-1:0] pp;
   logic [N:0]   c;

   always_comb begin
      p  = a ^ b;
      gg = a & b;
      pp = p;
      for (int d = 1; d < N; d = d * 2) begin
         for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      // gaps left by the up-sweep take the prefix ending just below them
      for (int d = DTOP; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         c[i+1] = gg[i] | (pp[i] & cin);
      end
   end

   assign sum  = p ^ c[N-1:0];
   assign cout = c[N];

endmodule

// File: rtl/bk_limb_stream_adder.sv
// Streaming multi-precision adder, one limb per beat, LS limb first.
// Carry chains across beats through a register; outputs are registered.
module bk_limb_stream_adder
   import bk_pkg::*;
#(
   parameter int ADDER_SIZE = BK_ADDER_SIZE,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDER_SIZE-1:0] in_op1,
   input  logic [ADDER_SIZE-1:0] in_op2,
   input  logic                  in_cin,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDER_SIZE-1:0] out_res,
   output logic                  out_last,
   output logic                  out_cout,
   output logic                  out_ovf,
   output logic [CNT_W-1:0]      out_idx
);

   localparam int MSB = ADDER_SIZE - 1;

   bk_stream_state_t state;
   bk_stream_state_t state_nxt;

   logic                  accept;
   logic                  carry;
   logic                  cin;
   logic                  cout;
   logic                  ovf;
   logic [ADDER_SIZE-1:0] sum;
   logic [CNT_W-1:0]      idx_nxt;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   brent_kung_adder_nbit #(
      .ADDER_SIZE(ADDER_SIZE)
   ) u_adder (
      .a   (in_op1),
      .b   (in_op2),
      .cin (cin),
      .sum (sum),
      .cout(cout)
   );

   assign ovf = in_last && (in_op1[MSB] == in_op2[MSB])
             && (sum[MSB] != in_op1[MSB]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cin       = carry;
      idx_nxt   = out_idx + 1'b1;
      unique case (state)
         IDLE: begin
            cin     = in_cin;
            idx_nxt = '0;
            if (accept && !in_last) state_nxt = BUSY;
         end
         BUSY: begin
            if (accept && in_last) state_nxt = IDLE;
         end
      endcase
   end

   // out_idx doubles as the limb counter: it only moves on accepted beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry     <= 1'b0;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_idx   <= '0;
      end else if (accept) begin
         carry     <= cout;
         out_valid <= 1'b1;
         out_res   <= sum;
         out_last  <= in_last;
         out_cout  <= cout;
         out_ovf   <= ovf;
         out_idx   <= idx_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bk_limb_stream_adder.sv
// Scoreboard bench for the limb stream adder.
// Expected beats are queued on acceptance and popped on output handshake.
module tb_bk_limb_stream_adder;

   typedef struct packed {
      logic [31:0] res;
      logic        cout;
      logic        last;
      logic        ovf;
      logic [7:0]  idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_op1 = '0;
   logic [31:0] in_op2 = '0;
   logic        in_cin = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_res;
   logic        out_last;
   logic        out_cout;
   logic        out_ovf;
   logic [7:0]  out_idx;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic done = 1'b0;

   always #5 clk = ~clk;

   bk_limb_stream_adder #(
      .ADDER_SIZE(32),
      .CNT_W     (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op1   (in_op1),
      .in_op2   (in_op2),
      .in_cin   (in_cin),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_res  (out_res),
      .out_last (out_last),
      .out_cout (out_cout),
      .out_ovf  (out_ovf),
      .out_idx  (out_idx)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         chk("sb_nonempty", 64'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res", out_res, e.res);
            chk("cout", out_cout, e.cout);
            chk("last", out_last, e.last);
            chk("ovf", out_ovf, e.ovf);
            chk("idx", out_idx, e.idx);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic l, input exp_t e);
      int n;
      n = 0;
      in_op1   = a;
      in_op2   = b;
      in_cin   = c;
      in_last  = l;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 64'(n), 0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sb.size() > 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 64'(sb.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input int n, input logic [159:0] a,
                          input logic [159:0] b, input logic c);
      logic [191:0] s;
      logic [191:0] m;
      logic         cc;
      exp_t         e;
      for (int i = 0; i < n; i++) begin
         m      = {192{1'b1}} >> (192 - 32 * (i + 1));
         s      = ({32'b0, a} & m) + ({32'b0, b} & m) + 192'(c);
         e.res  = s[32*i +: 32];
         e.cout = s[32*(i+1)];
         e.last = (i == n - 1);
         e.ovf  = e.last && (a[32*i+31] == b[32*i+31])
               && (s[32*i+31] != a[32*i+31]);
         e.idx  = 8'(i);
         cc     = (i == 0) ? c : 1'($urandom_range(0, 1));
         send(a[32*i +: 32], b[32*i +: 32], cc, e.last, e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [159:0] ra;
      logic [159:0] rb;
      int           nl;

      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_res", out_res, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_cout", out_cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0, 8'd0});
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b0, 8'd0});
      send(32'h0, 32'h0, 1'b0, 1'b1, '{32'h1, 1'b0, 1'b1, 1'b0, 8'd1});
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1,
           '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 8'd0});
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0, 8'd0});
      send(32'h0, 32'h0, 1'b0, 1'b1, '{32'h0, 1'b0, 1'b1, 1'b0, 8'd0});
      wait_drain();

      out_ready = 1'b0;
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b0, 8'd0});
      fork
         send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0,
              '{32'h0, 1'b1, 1'b0, 1'b0, 8'd1});
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp_ready", in_ready, 0);
               chk("bp_valid", out_valid, 1);
               chk("bp_res", out_res, 0);
               chk("bp_cout", out_cout, 1);
               chk("bp_idx", out_idx, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      send(32'h0, 32'h0, 1'b0, 1'b0, '{32'h1, 1'b0, 1'b0, 1'b0, 8'd2});
      send(32'h5, 32'h7, 1'b0, 1'b1, '{32'hC, 1'b0, 1'b1, 1'b0, 8'd3});
      wait_drain();

      out_ready = 1'b0;
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b0, 8'd0});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cout", out_cout, 0);
      chk("mid_rst_res", out_res, 0);
      chk("mid_rst_idx", out_idx, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_ready", in_ready, 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h0, 32'h0, 1'b0, 1'b1, '{32'h0, 1'b0, 1'b1, 1'b0, 8'd0});
      wait_drain();

      fork
         begin
            for (int t = 0; t < 200; t++) begin
               nl = $urandom_range(1, 5);
               ra = {$urandom, $urandom, $urandom, $urandom, $urandom};
               rb = {$urandom, $urandom, $urandom, $urandom, $urandom};
               if ($urandom_range(0, 3) == 0) rb = ~ra;
               run_txn(nl, ra, rb, 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
